// File: rtl/mux_pkg.sv
// Package for mux_nx1_arb: default geometry constants and the channel-index width helper.
//   DefaultWidth  default data bits per channel
//   DefaultNumCh  default number of input channels
//   ch_w_safe()   channel-index width, at least 1 bit even for degenerate channel counts
package mux_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultNumCh = 2;

  function automatic int unsigned ch_w_safe(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Channel arbiter for mux_nx1_arb.
// Macro MUX_ROUND_ROBIN_EN selects round-robin arbitration with an internal rotating
// pointer; without it the arbiter is fixed priority (lowest requesting index wins) and
// keeps no state.
// Ports:
//   clk        rising-edge clock (pointer update only)
//   reset      asynchronous active-low reset (pointer returns to 0)
//   req        per-channel request vector
//   advance    a transfer took place on the granted channel this cycle
//   grant      one-hot grant, all zero when nothing requests
//   grant_idx  binary index of the granted channel (0 when nothing requests)
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned NUM_CH = DefaultNumCh,
  parameter int unsigned CH_W   = ch_w_safe(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx
);

`ifdef MUX_ROUND_ROBIN_EN

  logic [CH_W-1:0] ptr_q, ptr_d;
  logic [CH_W:0]   sum;
  logic [CH_W-1:0] idx;
  logic            found;

  // Scan channels starting at the pointer, wrapping past NUM_CH-1 back to 0.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum = {1'b0, ptr_q} + (CH_W + 1)'(k);
      if (sum >= (CH_W + 1)'(NUM_CH)) begin
        sum = sum - (CH_W + 1)'(NUM_CH);
      end
      idx = sum[CH_W-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  // Pointer moves just past the channel that transferred; otherwise it holds.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

`else

  logic found;
  logic unused_fixed;

  // Fixed priority keeps no state, so clock, reset and advance are intentionally unused.
  assign unused_fixed = clk ^ reset ^ advance;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && req[k]) begin
        found     = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = CH_W'(k);
      end
    end
  end

`endif

endmodule

// File: rtl/mux_nx1_arb.sv
// N-to-1 arbitrated multiplexer with a single registered output stage.
// Macro MUX_ROUND_ROBIN_EN selects round-robin arbitration; the default build is fixed
// priority (lowest requesting index wins).
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_data    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel request
//   in_ready   per-channel accept, at most one bit high
//   out        registered selected data
//   out_valid  out holds a word
//   out_ready  downstream accept
//   out_ch     index of the channel that sourced out
module mux_nx1_arb
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH  = DefaultWidth,
  parameter int unsigned NUM_CH = DefaultNumCh,
  parameter int unsigned CH_W   = ch_w_safe(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*WIDTH-1:0]  in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [WIDTH-1:0]         out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch
);

  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic [WIDTH-1:0]  sel_data;
  logic              load;
  logic              transfer;

  logic [WIDTH-1:0]  out_q;
  logic              out_valid_q;
  logic [CH_W-1:0]   out_ch_q;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (in_valid),
    .advance   (transfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Output register can take a new word when empty or draining this cycle.
  assign load = !out_valid_q || out_ready;

  // Gating with reset keeps every in_ready low while reset is held.
  assign in_ready = reset ? (grant & {NUM_CH{load}}) : '0;
  assign transfer = |in_ready;

  // One-hot AND-OR select; grant has at most one bit set.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sel_data = sel_data | (in_data[k*WIDTH +: WIDTH] & {WIDTH{grant[k]}});
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
    end else if (transfer) begin
      out_q       <= sel_data;
      out_valid_q <= 1'b1;
      out_ch_q    <= grant_idx;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_nx1_arb.sv
// Self-checking bench for mux_nx1_arb (NUM_CH=4, WIDTH=8) against a behavioural model.
// Honours MUX_ROUND_ROBIN_EN the same way as the design.
module tb_mux_nx1_arb;

  localparam int WIDTH  = 8;
  localparam int NUM_CH = 4;

  logic                    clk;
  logic                    reset;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [WIDTH-1:0]        out;
  logic                    out_valid;
  logic                    out_ready;
  logic [1:0]              out_ch;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int         m_ptr;
  logic [7:0] m_out;
  logic       m_ovalid;
  int         m_ch;

  mux_nx1_arb #(
    .WIDTH  (WIDTH),
    .NUM_CH (NUM_CH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr    = 0;
    m_out    = '0;
    m_ovalid = 1'b0;
    m_ch     = 0;
  endtask

  // Returns the granted channel or -1 when nobody is accepted this cycle.
  function automatic int model_pick(input logic [3:0] v, input logic ordy);
    int idx;
    if (m_ovalid && !ordy) return -1;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (m_ptr + k) % NUM_CH;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Drive one cycle at the falling edge, check, then advance the model at the rising edge.
  task automatic step(input logic [3:0] v, input logic [31:0] d, input logic ordy);
    int         g;
    logic [3:0] er;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    #1;
    g  = model_pick(v, ordy);
    er = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    check("in_ready", {28'd0, in_ready}, {28'd0, er});
    check("out", {24'd0, out}, {24'd0, m_out});
    check("out_valid", {31'd0, out_valid}, {31'd0, m_ovalid});
    check("out_ch", {30'd0, out_ch}, m_ch);
    @(posedge clk);
    if (g >= 0) begin
      m_out    = d[g*8 +: 8];
      m_ch     = g;
      m_ovalid = 1'b1;
`ifdef MUX_ROUND_ROBIN_EN
      m_ptr = (g + 1) % NUM_CH;
`endif
    end else if (ordy) begin
      m_ovalid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b0;
    in_valid = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Idle after reset release
    for (int i = 0; i < 5; i++) begin
      step(4'b0000, $urandom, 1'b1);
      #1;
      check("idle_out", {24'd0, out}, 32'h00);
      check("idle_valid", {31'd0, out_valid}, 32'd0);
    end

    // Single channel 2
    step(4'b0100, 32'h00A5_0000, 1'b1);
    #1;
    check("single_out", {24'd0, out}, 32'hA5);
    check("single_ch", {30'd0, out_ch}, 32'd2);
    check("single_valid", {31'd0, out_valid}, 32'd1);

    do_reset();
`ifdef MUX_ROUND_ROBIN_EN
    for (int i = 0; i < 6; i++) begin
      step(4'b1111, $urandom, 1'b1);
      #1;
      check("rr_seq", {30'd0, out_ch}, i % 4);
    end
`else
    for (int i = 0; i < 6; i++) begin
      step(4'b1010, $urandom, 1'b1);
      #1;
      check("fixed_ch", {30'd0, out_ch}, 32'd1);
    end
`endif

    // Backpressure with channel 1 holding 0x3C
    step(4'b0010, 32'h0000_3C00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(4'b0010, 32'h0000_3C00, 1'b0);
      #1;
      check("bp_out", {24'd0, out}, 32'h3C);
      check("bp_ready", {28'd0, in_ready}, 32'd0);
    end
    step(4'b0010, 32'h0000_5A00, 1'b1);
    #1;
    check("bp_next_out", {24'd0, out}, 32'h5A);
    check("bp_next_valid", {31'd0, out_valid}, 32'd1);

    // Asynchronous reset while a word is held
    step(4'b0001, 32'h0000_0077, 1'b0);
    @(negedge clk);
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out", {24'd0, out}, 32'd0);
    check("arst_ready", {28'd0, in_ready}, 32'd0);
    model_reset();
    in_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step(4'b1001, 32'h1100_0022, 1'b1);
    #1;
    check("arst_first_ch", {30'd0, out_ch}, 32'd0);
    check("arst_first_out", {24'd0, out}, 32'h22);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_nx1_arb.md
MUX_NX1_ARB -- requirements
Module: mux_nx1_arb

Interface
REQ-001 Parameter WIDTH, default 8: data bits per channel, legal range 1..64.
REQ-002 Parameter NUM_CH, default 2: number of input channels, legal range 2..16.
REQ-003 Parameter CH_W, default $clog2(NUM_CH): channel-index width, derived and not overridden.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  NUM_CH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  NUM_CH  per-channel request; bit i qualifies channel i.
REQ-008 in_ready  output  NUM_CH  per-channel accept; at most one bit high in any cycle.
REQ-009 out  output  WIDTH  registered selected data.
REQ-010 out_valid  output  1  out holds a word.
REQ-011 out_ready  input  1  downstream accept.
REQ-012 out_ch  output  CH_W  index of the channel that sourced out.

Function
REQ-013 A transfer on channel i occurs in a cycle where in_valid[i] and in_ready[i] are both 1; a transfer on the output occurs where out_valid and out_ready are both 1.
REQ-014 Output stage is a single register; it can load when out_valid==0 or out_ready==1 (load-while-drain allowed, no bubble).
REQ-015 in_ready[i] is 1 only when channel i holds the grant, in_valid[i]==1, the output stage can load, and reset is deasserted.
REQ-016 On a channel-i transfer, the next cycle shows out=channel i data, out_ch=i, out_valid=1 (1-cycle latency).
REQ-017 An output transfer with no simultaneous input transfer clears out_valid next cycle; out and out_ch hold their values.
REQ-018 With out_valid==1 and out_ready==0, out, out_ch, and out_valid hold stable, and all in_ready bits are 0.
REQ-019 Grant (round-robin mode): the first requesting channel at or after pointer ptr, wrapping from NUM_CH-1 to 0.
REQ-020 After a channel-g transfer, ptr becomes g+1 modulo NUM_CH; without a transfer, ptr holds.
REQ-021 No requesters means no grant, all in_ready 0, and ptr unchanged.
REQ-022 Input in_valid is not required to be held; withdrawal before a transfer is legal, and the grant is re-evaluated each cycle.
REQ-023 Throughput is one word per cycle while out_ready is held at 1 and any channel requests.

Reset
REQ-024 While reset==0, the block asynchronously forces out=0, out_valid=0, out_ch=0, ptr=0, and all in_ready=0.
REQ-025 Reset asserted mid-transfer discards the output word; after release, the first grant goes to the lowest-index requester.
REQ-026 The first transfer can occur on the first rising edge after reset returns to 1.

Configuration
REQ-027 With macro MUX_ROUND_ROBIN_EN defined, arbitration follows REQ-019/REQ-020.
REQ-028 With MUX_ROUND_ROBIN_EN undefined, arbitration is fixed priority (lowest requesting index wins); ptr does not exist and all other behaviour is unchanged.

Structure
REQ-029 Package mux_pkg holds the default WIDTH/NUM_CH constants and a clog2-safe CH_W helper constant function.
REQ-030 Sub-module rr_arbiter (request vector, ptr, advance -> one-hot grant, grant index) holds the arbitration; the top holds the mux and the output register.
REQ-031 The data mux is one-hot AND-OR indexed by the grant; no priority chain on the data path.

Verification (NUM_CH=4, WIDTH=8 unless noted)
REQ-032 Reset release, all valid 0 -> out=0x00, out_valid=0, in_ready=4'b0000 for 5 cycles.
REQ-033 Single channel: ch2 valid with 0xA5, out_ready=1 -> in_ready=4'b0100; next cycle out=0xA5, out_ch=2, out_valid=1.
REQ-034 Round-robin: all 4 valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles.
REQ-035 Backpressure: out_ready=0 for 3 cycles with ch1 holding 0x3C -> out stable at 0x3C, in_ready=0; on out_ready=1, the next word follows with no bubble.
REQ-036 Mid-operation reset: assert reset==0 while out_valid=1 -> out_valid=0 immediately without waiting for clk; after release, ch0 and ch3 valid -> first grant is ch0.
REQ-037 MUX_ROUND_ROBIN_EN undefined: ch1 and ch3 valid continuously, out_ready=1 -> out_ch=1 on every cycle, and ch3 is never granted.
